// File: rtl/scr1_dmem_resp_pkg.sv
// Shared types, FSM encoding and byte-enable helper for the scr1_dmem_resp_sram responder.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_resp_pkg;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } type_scr1_dmem_resp_fsm_e;

  // Wait counter holds LATENCY-1, LATENCY is at most 15.
  localparam int SCR1_DMEM_RESP_CNT_W = 4;

  function automatic logic [3:0] scr1_dmem_resp_be(input type_scr1_mem_width_e width,
                                                    input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << addr_lo;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << {addr_lo[1], 1'b0};
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_dmem_resp_ram.sv
// MEM_WORDS x 32 SRAM split into four byte lanes; byte-enable write, registered read.
module scr1_dmem_resp_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    logic [7:0] lane_reg;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[idx] <= wdata[8*gi +: 8];
      end
      if (re) begin
        lane_reg <= lane_mem[idx];
      end
    end

    assign rdata[8*gi +: 8] = lane_reg;
  end

endmodule

// File: rtl/scr1_dmem_resp_sram.sv
// SCR1 DMEM target responder over a local SRAM window with LATENCY wait states.
// Optional error checking (misalignment, range, bad encodings) under SCR1_DMEM_RESP_ERR_CHECK_EN.
module scr1_dmem_resp_sram
  import scr1_dmem_resp_pkg::*;
#(
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_RESP_BASE = `SCR1_DMEM_AWIDTH'h00010000,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = SCR1_DMEM_RESP_CNT_W;
  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  type_scr1_dmem_resp_fsm_e state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic rd_reg, rd_next;
  logic err_reg, err_next;

  logic accept;
  logic is_wr;
  logic req_err;
  logic [3:0] be;
  logic [`SCR1_DMEM_AWIDTH-1:0] offset;
  logic [IDX_W-1:0] idx;
  logic [31:0] ram_rdata;
  logic unused_offset;

  assign dmem_req_ack = (state_reg != WAIT);
  // Reset wins over a coincident request so nothing is committed at the reset edge.
  assign accept = dmem_req & dmem_req_ack & ~rst;
  assign is_wr  = (dmem_cmd == SCR1_MEM_CMD_WR);
  assign be     = scr1_dmem_resp_be(dmem_width, dmem_addr[1:0]);
  assign offset = dmem_addr - SCR1_DMEM_RESP_BASE;
  assign idx    = offset[IDX_W+1:2];
  assign unused_offset = ^offset;

`ifdef SCR1_DMEM_RESP_ERR_CHECK_EN
  logic cmd_bad, width_bad, misaligned, out_of_range;
  assign cmd_bad      = (dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR);
  assign width_bad    = (dmem_width == SCR1_MEM_WIDTH_ERROR);
  assign misaligned   = ((dmem_width == SCR1_MEM_WIDTH_HWORD) && dmem_addr[0]) ||
                        ((dmem_width == SCR1_MEM_WIDTH_WORD) && (dmem_addr[1:0] != 2'b00));
  assign out_of_range = ((offset >> (IDX_W + 2)) != '0);
  assign req_err      = cmd_bad | width_bad | misaligned | out_of_range;
`else
  assign req_err = 1'b0;
`endif

  scr1_dmem_resp_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (accept & is_wr & ~req_err),
    .re    (accept & ~is_wr),
    .be    (be),
    .idx   (idx),
    .wdata (dmem_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_next    = rd_reg;
    err_next   = err_reg;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;

    case (state_reg)
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        dmem_resp  = err_reg ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        if (!err_reg && rd_reg) begin
          dmem_rdata = ram_rdata;
        end
        state_next = IDLE;
      end
      default: ;
    endcase

    // Acceptance is possible in IDLE and RESP alike, giving back-to-back pipelining.
    if (accept) begin
      state_next = (LATENCY == 0) ? RESP : WAIT;
      cnt_next   = LAT_M1;
      rd_next    = ~is_wr;
      err_next   = req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_reg    <= rd_next;
      err_reg   <= err_next;
    end
  end

endmodule
